// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
// Miss-handling responder for a 32-entry direct-mapped data cache
// (8-bit address, index = addr[4:0], tag = addr[7:5], 32-bit words).
// A processor read is looked up in the cache. A hit returns the cached word.
// A miss fetches the word from main memory over a level req / one-cycle ack
// handshake, writes it into the cache, and then returns it to the processor.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   cpu_req/cpu_addr     read request (sampled in IDLE) and its address
//   cpu_rdata/ready/err  one-cycle completion pulse with data or timeout flag
//   stall                high while a request is in flight
//   cache_sel/write/addr/wdata, cache_rdata/cache_miss   cache interface
//   mem_req/mem_addr, mem_ack/mem_rdata                  memory interface
module cache_refill_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [7:0]  cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        stall,
  output logic        cache_sel,
  output logic        cache_write,
  output logic [7:0]  cache_addr,
  output logic [31:0] cache_wdata,
  input  logic [31:0] cache_rdata,
  input  logic        cache_miss,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_WAIT,
    FILL,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       addr_q;
  logic [31:0]      data_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic             wait_last;

  // The last permitted memory-wait cycle; an ack arriving in it still wins.
  assign wait_last = (cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Address and fill data are plain views of the latched request, so they
  // read as zero after reset and stay stable for the whole memory wait.
  assign cache_addr  = addr_q;
  assign mem_addr    = addr_q;
  assign cache_wdata = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req) addr_q <= cpu_addr;
        end
        CHECK: begin
          cnt <= '0;
          if (!cache_miss) data_q <= cache_rdata;
        end
        MEM_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            data_q <= mem_rdata;
          end else if (wait_last) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_rdata   = '0;
    cpu_ready   = 1'b0;
    cpu_err     = 1'b0;
    cache_sel   = 1'b0;
    cache_write = 1'b0;
    mem_req     = 1'b0;
    stall       = (state != IDLE);
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        // Read strobe: the cache registers its data and miss flag on this edge.
        cache_sel = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = cache_miss ? MEM_WAIT : DONE;
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack)        state_nxt = FILL;
        else if (wait_last) state_nxt = DONE;
      end
      FILL: begin
        cache_sel   = 1'b1;
        cache_write = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        cpu_ready = 1'b1;
        cpu_rdata = data_q;
        cpu_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling responder for the 32-entry direct-mapped data cache (8-bit address, index = addr[4:0], 3-bit tag = addr[7:5], 32-bit word).
- Accepts processor read requests and runs a cache lookup.
- On a hit, returns the cached word.
- On a miss, fetches the word from main memory over a req/ack handshake, writes it into the cache, and forwards it to the processor.
- Sits between the pipeline MEM stage, the cache, and main memory. It drives the cache's chip-select, write, address and data inputs.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ack before aborting with error (≥2)
CNT_W, 5, width of timeout counter (must hold MEM_TIMEOUT)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  read request, sampled only in IDLE
cpu_addr  input  8  request address, latched on acceptance
cpu_rdata  output  32  returned word, valid while cpu_ready=1
cpu_ready  output  1  one-cycle completion pulse
cpu_err  output  1  qualifies cpu_ready: memory timeout, cpu_rdata=0
stall  output  1  high whenever state != IDLE
cache_sel  output  1  cache chip-select
cache_write  output  1  cache write enable
cache_addr  output  8  cache address (latched request address)
cache_wdata  output  32  fill data; top level drives cache dat with it only when cache_sel & cache_write
cache_rdata  input  32  cache dat bus as seen by controller
cache_miss  input  1  cache miss flag
mem_req  output  1  memory read request, level
mem_addr  output  8  memory address, stable while mem_req=1
mem_ack  input  1  memory data-valid strobe, one cycle
mem_rdata  input  32  memory read data, valid with mem_ack

Behaviour:
- Reset (synchronous, takes priority in any state, including mid-fill or mid-memory-wait):
  - state=IDLE.
  - All outputs 0: cpu_rdata=0, cpu_ready=0, cpu_err=0, stall=0, cache_sel=0, cache_write=0, cache_addr=0, cache_wdata=0, mem_req=0, mem_addr=0.
  - Timeout counter=0. An interrupted memory request is dropped; a late mem_ack after reset is ignored.
- States: IDLE, LOOKUP, CHECK, MEM_WAIT, FILL, DONE (encoding free).
- IDLE:
  - If cpu_req=1, latch cpu_addr into addr_q and go to LOOKUP.
  - cpu_req=0 stays in IDLE. All strobes 0.
- LOOKUP:
  - cache_sel=1, cache_write=0, cache_addr=addr_q.
  - The cache registers outDat/miss on this edge. Go to CHECK.
- CHECK:
  - cache_sel=0. Sample cache_miss and cache_rdata.
  - Miss=0: data_q<=cache_rdata, go to DONE.
  - Miss=1: go to MEM_WAIT with counter cleared.
- MEM_WAIT:
  - mem_req=1, mem_addr=addr_q. The counter increments each cycle.
  - mem_ack=1: data_q<=mem_rdata, go to FILL. Ack wins if it coincides with counter reaching MEM_TIMEOUT.
  - Counter==MEM_TIMEOUT-1 with no ack: err_q<=1, data_q<=0, go to DONE with no fill.
  - mem_ack outside MEM_WAIT is ignored.
- FILL:
  - cache_sel=1, cache_write=1, cache_addr=addr_q, cache_wdata=data_q. Exactly one cycle.
  - The cache stores {addr_q[7:5], data_q} at index addr_q[4:0] and clears miss. Go to DONE.
- DONE:
  - cpu_ready=1, cpu_rdata=data_q, cpu_err=err_q. Exactly one cycle.
  - Clear err_q, go to IDLE.
  - A cpu_req asserted in DONE is not accepted; it is accepted on the following IDLE cycle if still held.
- stall=1 in every state except IDLE. It rises the cycle after acceptance and falls the cycle after DONE.
- Latency from the cpu_req-accept edge to cpu_ready:
  - hit: 3 cycles.
  - miss: 4 + N cycles, where N = cycles spent in MEM_WAIT including the ack cycle.
  - timeout: 3 + MEM_TIMEOUT cycles.
- Throughput: one request per 4 cycles on hits. No request queuing; cpu_req is ignored while busy.
- cache_sel & ~cache_write is asserted only in LOOKUP; the top level must not drive cache dat then (no bus contention).
- Write requests are out of scope for this block: processor stores go direct to the cache.

Test Plan:
- Cold miss: reset, cache line 5 holds tag 3; cpu_req addr=0x25 → LOOKUP/CHECK, miss=1 → mem_req=1, mem_addr=0x25; ack after 3 cycles with 0xDEADBEEF → FILL writes {3'b001,0xDEADBEEF} at index 5 → cpu_ready pulse, cpu_rdata=0xDEADBEEF, cpu_err=0, total 7 cycles.
- Hit after fill: repeat cpu_req addr=0x25 → no mem_req, cpu_ready 3 cycles after accept, cpu_rdata=0xDEADBEEF.
- Conflict miss: cpu_req addr=0xA5 (same index 5, tag 5) → miss, fetch 0x12345678, cache line 5 tag=5. Then cpu_req 0x25 → miss again.
- Timeout: MEM_TIMEOUT=16, mem_ack held 0 → mem_req high exactly 16 cycles, cpu_ready with cpu_err=1, cpu_rdata=0, cache_write never asserted.
- Reset mid-op: assert reset during MEM_WAIT cycle 2 → next cycle all outputs 0, state IDLE; a stray mem_ack 2 cycles later produces no cache_write and no cpu_ready.
- Back-to-back/held request: cpu_req held high continuously with hits → cpu_ready every 4 cycles, stall low exactly one cycle between requests; ack coincident with timeout boundary → data accepted, cpu_err=0.
